// File: rtl/stage_mem_access_pkg.sv
// stage_mem_access_pkg: shared encodings and constants for the memory-access stage
package stage_mem_access_pkg;
  localparam logic [2:0] MS_WORD = 3'd0, MS_HU = 3'd1, MS_HS = 3'd2, MS_BU = 3'd3, MS_BS = 3'd4;
  localparam logic [4:0] EXC_NONE = 5'd0, EXC_ADEL = 5'd4, EXC_ADES = 5'd5;
  localparam logic [31:0] RESET_PC = 32'h0000_3000, HANDLER_PC = 32'h0000_4180;
  typedef enum logic {IDLE, WAIT} state_t;
  function automatic logic is_half(input logic [2:0] sel);
    return sel == MS_HU || sel == MS_HS;
  endfunction
  function automatic logic is_byte(input logic [2:0] sel);
    return sel == MS_BU || sel == MS_BS;
  endfunction
endpackage

// File: rtl/stage_mem_access_align.sv
// mem_lane_align: byte enables, store lane replication and load lane extraction/extension
module mem_lane_align
  import stage_mem_access_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata_ext
);
  logic [15:0] half_v;
  logic [7:0]  byte_v;
  assign half_v = addr[1] ? rdata_in[31:16] : rdata_in[15:0];
  assign byte_v = rdata_in[{addr, 3'b000} +: 8];
  assign be = is_half(sel) ? 4'b0011 << {addr[1], 1'b0} : is_byte(sel) ? 4'b0001 << addr : 4'b1111;
  assign wdata = is_half(sel) ? {2{wdata_in[15:0]}} : is_byte(sel) ? {4{wdata_in[7:0]}} : wdata_in;
  assign rdata_ext = is_half(sel) ? {{16{sel == MS_HS && half_v[15]}}, half_v} :
                     is_byte(sel) ? {{24{sel == MS_BS && byte_v[7]}}, byte_v} : rdata_in;
endmodule

// File: rtl/stage_mem_access.sv
// stage_mem_access: M stage with address checks, valid/ready data-memory access and M/W register
module stage_mem_access
  import stage_mem_access_pkg::*;
#(
  parameter logic [31:0] DM_LIMIT = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        RegWrite_in,
  input  logic        MemWrite_in,
  input  logic        MemToReg_in,
  input  logic [31:0] ALUOut_in,
  input  logic [31:0] WriteData_in,
  input  logic [4:0]  RegAddr_in,
  input  logic [31:0] pc_in,
  input  logic [2:0]  MemSel_in,
  input  logic [4:0]  exc_in,
  output logic        stall,
  output logic [4:0]  exc_out,
  output logic [31:0] bad_addr,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic        RegWrite_w,
  output logic [4:0]  RegAddr_w,
  output logic [31:0] Result_w,
  output logic [31:0] pc_w
);
  state_t state, state_nx;
  logic flush_pending, mem_op, fault, issue, bubble;
  logic [3:0] be;
  logic [31:0] wdata, rdata_ext;
  mem_lane_align u_align (
    .sel(MemSel_in), .addr(ALUOut_in[1:0]), .wdata_in(WriteData_in), .rdata_in(bus_rdata),
    .be(be), .wdata(wdata), .rdata_ext(rdata_ext)
  );
  assign mem_op = MemWrite_in | MemToReg_in;
  // word-class selects (0 and the undefined 5..7) need 4-byte alignment
  assign fault = exc_in == EXC_NONE && mem_op && (ALUOut_in >= DM_LIMIT ||
                 (is_half(MemSel_in) ? ALUOut_in[0] : !is_byte(MemSel_in) && ALUOut_in[1:0] != 2'b00));
  assign exc_out = exc_in != EXC_NONE ? exc_in : fault ? (MemWrite_in ? EXC_ADES : EXC_ADEL) : EXC_NONE;
  assign bad_addr = ALUOut_in;
  always_comb begin
    issue = state == IDLE && mem_op && exc_in == EXC_NONE && !fault && !req;
    stall = issue || (state == WAIT && !bus_ready);
    bubble = req || (state == WAIT && flush_pending);
    state_nx = issue ? WAIT : (state == WAIT && bus_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus_valid <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_be <= '0;
      bus_wdata <= '0;
    end else if (issue) begin
      bus_valid <= 1'b1;
      bus_we <= MemWrite_in;
      bus_addr <= {ALUOut_in[31:2], 2'b00};
      bus_be <= be;
      bus_wdata <= wdata;
    end else if (state == WAIT && bus_ready) bus_valid <= 1'b0;
  // a flush seen mid-access is remembered and turns the completing instruction into a bubble
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) flush_pending <= 1'b0;
    else if (state == WAIT) flush_pending <= !bus_ready && (flush_pending || req);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      RegWrite_w <= 1'b0;
      RegAddr_w <= '0;
      Result_w <= '0;
      pc_w <= RESET_PC;
    end else if (!stall) begin
      RegWrite_w <= !bubble && RegWrite_in;
      RegAddr_w <= bubble ? '0 : RegAddr_in;
      Result_w <= bubble ? '0 : (state == WAIT && MemToReg_in) ? rdata_ext : ALUOut_in;
      pc_w <= bubble ? HANDLER_PC : pc_in;
    end
endmodule

// File: tb/tb_stage_mem_access.sv
// tb_stage_mem_access: directed vectors against a transaction-level model of the M stage
module tb_stage_mem_access;
  logic clk = 0, rst_n, req, RegWrite_in, MemWrite_in, MemToReg_in;
  logic [31:0] ALUOut_in, WriteData_in, pc_in, bad_addr, bus_addr, bus_wdata, bus_rdata, Result_w, pc_w;
  logic [4:0] RegAddr_in, exc_in, exc_out, RegAddr_w;
  logic [2:0] MemSel_in;
  logic stall, bus_valid, bus_we, bus_ready, RegWrite_w;
  logic [3:0] bus_be;
  int n_vec = 0, n_err = 0, n_st = 0, n_wr = 0;
  logic chk_en = 0;
  logic e_stall, e_bv, e_we, e_rw;
  logic [4:0] e_exc, e_ra;
  logic [31:0] e_bad, e_addr, e_wd, e_res, e_pc;
  logic [3:0] e_be, last_be;
  logic [31:0] last_addr, last_wd;

  stage_mem_access dut (
    .clk(clk), .rst_n(rst_n), .req(req), .RegWrite_in(RegWrite_in), .MemWrite_in(MemWrite_in),
    .MemToReg_in(MemToReg_in), .ALUOut_in(ALUOut_in), .WriteData_in(WriteData_in),
    .RegAddr_in(RegAddr_in), .pc_in(pc_in), .MemSel_in(MemSel_in), .exc_in(exc_in),
    .stall(stall), .exc_out(exc_out), .bad_addr(bad_addr), .bus_valid(bus_valid), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
    .bus_rdata(bus_rdata), .RegWrite_w(RegWrite_w), .RegAddr_w(RegAddr_w), .Result_w(Result_w), .pc_w(pc_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [2:0] s);
    return (s == 3'd1 || s == 3'd2) ? 2 : (s == 3'd3 || s == 3'd4) ? 1 : 4;
  endfunction
  function automatic logic [3:0] m_be(input logic [2:0] s, input logic [31:0] a);
    int mask;
    mask = ((1 << nbytes(s)) - 1) << (a % 4);
    return mask[3:0];
  endfunction
  function automatic logic [31:0] m_wd(input logic [2:0] s, input logic [31:0] wd);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes(s)) +: 8];
    return r;
  endfunction
  function automatic logic [31:0] m_ld(input logic [2:0] s, input logic [31:0] a, input logic [31:0] rd);
    int n;
    logic [31:0] v, mask;
    n = nbytes(s);
    if (n == 4) return rd;
    mask = (32'h1 << (8 * n)) - 1;
    v = (rd >> (8 * (a % 4))) & mask;
    if ((s == 3'd2 || s == 3'd4) && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  always @(negedge clk) if (chk_en) begin
    chk("stall", stall, e_stall);
    chk("exc_out", exc_out, e_exc);
    chk("bad_addr", bad_addr, e_bad);
    chk("bus_valid", bus_valid, e_bv);
    if (e_bv) begin
      chk("bus_we", bus_we, e_we);
      chk("bus_addr", bus_addr, e_addr);
      chk("bus_be", bus_be, e_be);
      chk("bus_wdata", bus_wdata, e_wd);
    end
    chk("RegWrite_w", RegWrite_w, e_rw);
    chk("RegAddr_w", RegAddr_w, e_ra);
    chk("Result_w", Result_w, e_res);
    chk("pc_w", pc_w, e_pc);
  end

  always @(negedge clk) begin
    if (stall) n_st++;
    if (bus_valid) begin
      last_be = bus_be;
      last_addr = bus_addr;
      last_wd = bus_wdata;
    end
  end
  always @(posedge clk) if (rst_n && bus_valid && bus_we && bus_ready) n_wr++;

  // lat = WAIT cycles with bus_ready low; req_at = WAIT cycle (1-based) in which req is raised
  task automatic op(input logic rw, input logic mw, input logic mtr, input logic [31:0] a,
                    input logic [31:0] wd, input logic [4:0] ra, input logic [31:0] pc,
                    input logic [2:0] sel, input logic [4:0] exc, input logic rq,
                    input int lat, input int req_at, input logic [31:0] rd);
    logic flt, iss, bub;
    logic [31:0] res;
    RegWrite_in = rw; MemWrite_in = mw; MemToReg_in = mtr; ALUOut_in = a; WriteData_in = wd;
    RegAddr_in = ra; pc_in = pc; MemSel_in = sel; exc_in = exc; req = rq; bus_ready = 0; bus_rdata = rd;
    flt = exc == 0 && (mw || mtr) && (a >= 32'h3000 || a % nbytes(sel) != 0);
    iss = (mw || mtr) && exc == 0 && !flt && !rq;
    e_exc = exc != 0 ? exc : flt ? (mw ? 5'd5 : 5'd4) : 5'd0;
    e_bad = a; e_bv = 0; e_stall = iss; chk_en = 1;
    @(posedge clk) #1;
    bub = rq;
    res = a;
    if (iss) begin
      e_bv = 1; e_we = mw; e_addr = a & ~32'h3; e_be = m_be(sel, a); e_wd = m_wd(sel, wd);
      for (int k = 1; k <= lat + 1; k++) begin
        req = (k == req_at);
        bub = bub | req;
        bus_ready = (k == lat + 1);
        e_stall = !bus_ready;
        @(posedge clk) #1;
      end
      bus_ready = 0; req = 0; e_bv = 0;
      if (mtr) res = m_ld(sel, a, rd);
    end
    e_rw = bub ? 1'b0 : rw;
    e_ra = bub ? 5'd0 : ra;
    e_res = bub ? 32'd0 : res;
    e_pc = bub ? 32'h4180 : pc;
  endtask

  initial begin
    int s_st, s_wr;
    rst_n = 0; req = 0; RegWrite_in = 0; MemWrite_in = 0; MemToReg_in = 0; ALUOut_in = 0;
    WriteData_in = 0; RegAddr_in = 0; pc_in = 0; MemSel_in = 0; exc_in = 0; bus_ready = 0; bus_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_pc_w", pc_w, 32'h3000);
    chk("rst_RegWrite_w", RegWrite_w, 0);
    chk("rst_Result_w", Result_w, 0);
    chk("rst_bus_be", bus_be, 0);
    e_rw = 0; e_ra = 0; e_res = 0; e_pc = 32'h3000;
    rst_n = 1;
    op(1, 0, 0, 32'h1234, 0, 5'd3, 32'h100, 3'd0, 0, 0, 0, 0, 0);
    chk("alu_result", Result_w, 32'h1234);
    chk("alu_no_bus", bus_valid, 0);
    s_st = n_st; s_wr = n_wr;
    op(0, 1, 0, 32'h10, 32'hAABBCCDD, 5'd0, 32'h104, 3'd0, 0, 0, 3, 0, 0);
    chk("sw_stall_cycles", n_st - s_st, 4);
    chk("sw_write_count", n_wr - s_wr, 1);
    chk("sw_be", last_be, 4'b1111);
    chk("sw_addr", last_addr, 32'h10);
    chk("sw_wdata", last_wd, 32'hAABBCCDD);
    op(1, 0, 1, 32'h13, 0, 5'd8, 32'h108, 3'd4, 0, 0, 0, 0, 32'h80112233);
    chk("lb_result", Result_w, 32'hFFFFFF80);
    chk("lb_be", last_be, 4'b1000);
    chk("lb_addr", last_addr, 32'h10);
    op(1, 0, 1, 32'h12, 0, 5'd9, 32'h10C, 3'd1, 0, 0, 1, 0, 32'h80112233);
    chk("lhu_result", Result_w, 32'h00008011);
    chk("lhu_be", last_be, 4'b1100);
    op(1, 0, 1, 32'h20, 0, 5'd10, 32'h110, 3'd2, 0, 0, 0, 0, 32'h0000F00F);
    chk("lh_result", Result_w, 32'hFFFFF00F);
    op(1, 0, 1, 32'h11, 0, 5'd11, 32'h114, 3'd3, 0, 0, 2, 0, 32'h80112233);
    chk("lbu_result", Result_w, 32'h00000022);
    op(0, 1, 0, 32'h15, 32'h000000AB, 5'd0, 32'h118, 3'd3, 0, 0, 0, 0, 0);
    chk("sb_be", last_be, 4'b0010);
    chk("sb_wdata", last_wd, 32'hABABABAB);
    op(0, 1, 0, 32'h16, 32'h00001234, 5'd0, 32'h11C, 3'd1, 0, 0, 1, 0, 0);
    chk("sh_be", last_be, 4'b1100);
    chk("sh_wdata", last_wd, 32'h12341234);
    op(1, 0, 1, 32'h2, 0, 5'd12, 32'h120, 3'd0, 0, 0, 0, 0, 0);
    chk("adel_code", exc_out, 5'd4);
    chk("adel_bad_addr", bad_addr, 32'h2);
    s_wr = n_wr;
    op(0, 1, 0, 32'h3000, 32'h55, 5'd0, 32'h124, 3'd0, 0, 0, 0, 0, 0);
    chk("ades_code", exc_out, 5'd5);
    chk("ades_bad_addr", bad_addr, 32'h3000);
    chk("ades_no_write", n_wr - s_wr, 0);
    op(1, 0, 1, 32'h3, 0, 5'd13, 32'h128, 3'd2, 0, 0, 0, 0, 0);
    op(1, 0, 1, 32'h40, 0, 5'd14, 32'h12C, 3'd0, 5'd10, 0, 0, 0, 0);
    chk("upstream_exc", exc_out, 5'd10);
    op(1, 0, 1, 32'h40, 0, 5'd15, 32'h130, 3'd0, 0, 0, 3, 2, 32'hDEADBEEF);
    chk("flush_pc_w", pc_w, 32'h4180);
    chk("flush_RegWrite_w", RegWrite_w, 0);
    op(1, 0, 1, 32'h44, 0, 5'd16, 32'h134, 3'd0, 0, 0, 1, 2, 32'h12345678);
    op(1, 0, 1, 32'h48, 0, 5'd17, 32'h138, 3'd0, 0, 1, 0, 0, 0);
    op(1, 0, 0, 32'h77, 0, 5'd18, 32'h13C, 3'd0, 0, 1, 0, 0, 0);
    op(1, 0, 0, 32'h99, 0, 5'd19, 32'h140, 3'd0, 0, 0, 0, 0, 0);
    chk_en = 0;
    RegWrite_in = 1; MemWrite_in = 0; MemToReg_in = 1; ALUOut_in = 32'h20; MemSel_in = 0;
    RegAddr_in = 5'd9; pc_in = 32'h200; exc_in = 0; req = 0; bus_ready = 0;
    @(posedge clk) #1;
    chk("rst_mid_wait_pre", bus_valid, 1);
    bus_ready = 1;
    #2 rst_n = 0;
    #1;
    chk("rst_mid_wait_bv", bus_valid, 0);
    chk("rst_mid_wait_pc", pc_w, 32'h3000);
    chk("rst_mid_wait_rw", RegWrite_w, 0);
    chk("rst_mid_wait_idle", stall, 1);
    bus_ready = 0;
    @(posedge clk) #1;
    rst_n = 1;
    e_rw = 0; e_ra = 0; e_res = 0; e_pc = 32'h3000;
    op(1, 0, 1, 32'h24, 0, 5'd20, 32'h204, 3'd6, 0, 0, 1, 0, 32'h11223344);
    chk("sel6_word", Result_w, 32'h11223344);
    op(0, 0, 0, 32'h0, 0, 5'd0, 32'h208, 3'd0, 0, 0, 0, 0, 0);
    op(0, 0, 0, 32'h0, 0, 5'd0, 32'h20C, 3'd0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/stage_mem_access.md
Name: stage_mem_access

Overview:
- Memory-access stage between the E/M pipeline register and the W stage of the five-stage MIPS core.
- Consumes the M-stage register outputs and checks addresses for AdEL/AdES.
- Performs loads and stores over a valid/ready data-memory bus, stalling the pipeline while an access is outstanding.
- Holds the M/W pipeline register and presents the final result (load data or ALU result) to writeback.

Parameters:
- DM_LIMIT, 32'h0000_3000, first byte address outside data memory; any address >= DM_LIMIT faults.
- RESET_PC, 32'h0000_3000, pc_w value after reset.
- HANDLER_PC, 32'h0000_4180, pc_w value for a flush bubble.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  1  CP0 flush request (exception or interrupt taken).
- RegWrite_in  in  1  M-stage register write enable.
- MemWrite_in  in  1  store.
- MemToReg_in  in  1  load.
- ALUOut_in  in  32  effective address or ALU result.
- WriteData_in  in  32  store data.
- RegAddr_in  in  5  destination register.
- pc_in  in  32  M-stage PC.
- MemSel_in  in  3  0 = word, 1 = half zero-extended, 2 = half sign-extended, 3 = byte zero-extended, 4 = byte sign-extended.
- exc_in  in  5  upstream exception code, 0 = none.
- stall  out  1  freeze F/D/E/M registers.
- exc_out  out  5  exception code to CP0.
- bad_addr  out  32  faulting address to CP0 BadVAddr.
- bus_valid  out  1  access request.
- bus_we  out  1  write access.
- bus_addr  out  32  word-aligned address.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-shifted store data.
- bus_ready  in  1  access complete (write accepted / rdata valid).
- bus_rdata  in  32  read data, valid when bus_ready.
- RegWrite_w  out  1  W-stage write enable.
- RegAddr_w  out  5  W-stage destination register.
- Result_w  out  32  W-stage write data.
- pc_w  out  32  W-stage PC.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, bus_valid=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0.
  - RegWrite_w=0, RegAddr_w=0, Result_w=0, pc_w=RESET_PC, flush_pending=0.
  - A reset in WAIT drops bus_valid immediately; the access is abandoned.
- mem_op = MemWrite_in | MemToReg_in.
- fault: exc_in==0 and mem_op, and any of:
  - word access with addr[1:0]!=0;
  - half access with addr[0]!=0;
  - addr>=DM_LIMIT.
- exc_out (combinational):
  - exc_in when exc_in!=0;
  - else 4 (AdEL) on a load fault, 5 (AdES) on a store fault;
  - else 0.
- bad_addr = ALUOut_in (combinational).
- FSM has two states, IDLE and WAIT.
- IDLE:
  - If mem_op, exc_in==0, !fault and !req: stall=1; at the edge, latch the request and go to WAIT.
    - Latched request: bus_valid=1, bus_we=MemWrite_in, bus_addr={addr[31:2],2'b00}, bus_be, bus_wdata.
  - Otherwise stall=0 and the W register loads at the edge:
    - if req, a bubble: RegWrite_w=0, RegAddr_w=0, Result_w=0, pc_w=HANDLER_PC;
    - else RegWrite_in, RegAddr_in, ALUOut_in, pc_in.
  - A faulting or excepted instruction performs no bus access.
- WAIT:
  - Bus outputs are held stable until bus_ready.
  - req while in WAIT sets flush_pending; the access is not aborted.
  - bus_ready=0: stall=1, W register holds.
  - bus_ready=1: stall=0; at the edge bus_valid->0, state->IDLE, and the W register loads either:
    - a bubble if (flush_pending | req), clearing flush_pending;
    - else RegWrite_in, RegAddr_in, pc_in and Result_w = load ? extended data : ALUOut_in.
- Timing:
  - Minimum occupancy is 2 cycles: issue cycle, then bus_ready in the first WAIT cycle.
  - A new request is never issued in the same cycle bus_ready is seen.
- Byte enables: word=4'b1111; half=4'b0011<<(addr[1]*2); byte=4'b0001<<addr[1:0].
- Store data: wdata replicated into the selected lanes.
- Load data: selected lane, zero- or sign-extended per MemSel. MemSel 5..7 is treated as word.

Decomposition:
- Shared package: MemSel encodings, ExcCode constants (EXC_ADEL=4, EXC_ADES=5), RESET_PC and HANDLER_PC.
- Sub-module mem_lane_align (combinational): generates bus_be, store-lane shifting and load extension.
- The FSM and the W register stay in stage_mem_access.

Test Plan:
- Non-memory op, RegWrite_in=1, ALUOut_in=0x1234: stall stays 0; next edge Result_w=0x1234, bus_valid=0.
- sw to 0x10 with data 0xAABBCCDD, bus_ready 3 cycles after issue: stall=1 for 4 cycles; bus_be=1111; bus_addr=0x10; exactly one write.
- lb MemSel=4 at 0x13, rdata=0x80112233: bus_be=1000; Result_w=0xFFFFFF80. lhu MemSel=1 at 0x12, same rdata: Result_w=0x00008011.
- lw at 0x2 and sw at 0x3000: exc_out=4 and 5 respectively, bad_addr equals the address, bus_valid never asserts, stall=0.
- req asserted in the second WAIT cycle of a lw: access completes, then W gets a bubble with pc_w=0x4180 and RegWrite_w=0.
- rst_n pulled low mid-WAIT: bus_valid drops immediately, pc_w=0x3000, state returns to IDLE.
